// File: rtl/instruction_issue_queue.sv
// Circular instruction queue feeding MasterController: host enqueues words, the issue stage
// drops NOPs, parks on HALT until re-started, and presents one word per valid/ready handshake.
module instruction_issue_queue #(
    parameter int unsigned depth = 3,
    parameter int unsigned W     = 16,
    parameter int unsigned QA    = 5,
    localparam int unsigned InsW  = (depth > 2) ? depth : 2,
    localparam int unsigned InsD  = ((32'd1 << depth) > W) ? (32'd1 << depth) : W,
    localparam int unsigned INS_W = 4 + 2 + 2 * InsW + InsD
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             wrEn,
    input  logic [INS_W-1:0] wrData,
    output logic             full,
    output logic [QA:0]      count,
    output logic             overflow,
    output logic [INS_W-1:0] instruction,
    output logic             insValid,
    input  logic             insReady,
    output logic             running,
    output logic             halted
);

    localparam int unsigned Entries = 32'd1 << QA;
    localparam logic [3:0] OpNop  = 4'b0000;
    localparam logic [3:0] OpHalt = 4'b1111;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalted
    } state_e;

    state_e            state_q, state_d;
    logic [QA-1:0]     wr_ptr_q, wr_ptr_d;
    logic [QA-1:0]     rd_ptr_q, rd_ptr_d;
    logic [QA:0]       count_q, count_d;
    logic              full_q, full_d;
    logic              overflow_q, overflow_d;
    logic [INS_W-1:0]  ins_q, ins_d;
    logic              ins_valid_q, ins_valid_d;
    logic [INS_W-1:0]  mem_q [Entries];

    logic             push;
    logic             pop;
    logic [INS_W-1:0] head;
    logic [3:0]       head_op;
    logic             head_nop;
    logic             head_halt;

    // count_q is registered, so a word written into an empty queue cannot pop the same cycle.
    assign push      = wrEn && !full_q;
    assign pop       = (state_q == StRun) && (count_q != '0) && (!ins_valid_q || insReady);
    assign head      = mem_q[rd_ptr_q];
    assign head_op   = head[INS_W-1 -: 4];
    assign head_nop  = (head_op == OpNop);
    assign head_halt = (head_op == OpHalt);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StRun;
            StRun:    if (pop && head_halt) state_d = StHalted;
            StHalted: if (start) state_d = StRun;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (wrEn & full_q);
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == (QA+1)'(Entries));
    end

    // A completed transfer empties the slot unless a real instruction refills it this cycle.
    always_comb begin
        ins_d       = ins_q;
        ins_valid_d = ins_valid_q;
        if (ins_valid_q && insReady) begin
            ins_d       = '0;
            ins_valid_d = 1'b0;
        end
        if (pop && !head_nop && !head_halt) begin
            ins_d       = head;
            ins_valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            ins_q       <= '0;
            ins_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            ins_q       <= ins_d;
            ins_valid_q <= ins_valid_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge CLK) begin
        if (!RST && push) mem_q[wr_ptr_q] <= wrData;
    end

    assign full        = full_q;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign instruction = ins_q;
    assign insValid    = ins_valid_q;
    assign running     = (state_q == StRun);
    assign halted      = (state_q == StHalted);

endmodule

// File: tb/tb_instruction_issue_queue.sv
// Scoreboard bench for instruction_issue_queue with a 4-entry queue (QA=2).
module tb_instruction_issue_queue;

    localparam int unsigned QA = 2;
    localparam int unsigned IW = 28;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic          wrEn = 1'b0;
    logic [IW-1:0] wrData = '0;
    logic          insReady = 1'b0;
    logic          full, overflow, insValid, running, halted;
    logic [QA:0]   count;
    logic [IW-1:0] instruction;

    int vectors = 0;
    int miscompares = 0;
    logic [IW-1:0] exp_q[$];

    instruction_issue_queue #(
        .depth(3),
        .W(16),
        .QA(QA)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .start(start),
        .wrEn(wrEn),
        .wrData(wrData),
        .full(full),
        .count(count),
        .overflow(overflow),
        .instruction(instruction),
        .insValid(insValid),
        .insReady(insReady),
        .running(running),
        .halted(halted)
    );

    always #5 CLK = ~CLK;

    function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [23:0] tag);
        return {op, tag};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write(input logic [IW-1:0] w, input bit expect_out);
        wrEn   = 1'b1;
        wrData = w;
        if (expect_out) exp_q.push_back(w);
        tick();
        wrEn = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((count != 0 || insValid) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_drained"}, 32'(count != 0 || insValid), 32'd0);
        check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every accepted transfer must match the oldest expected word.
    always @(negedge CLK) begin
        if (!RST) begin
            if (insValid && insReady) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_unexpected: got %0h, expected none", instruction);
                end else begin
                    check("sb_order", 32'(instruction), 32'(exp_q.pop_front()));
                end
            end else if (!insValid) begin
                check("idle_zero", 32'(instruction), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int sent;
        int max_cnt;
        logic [IW-1:0] w5;

        tick();
        do_reset();
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_valid", 32'(insValid), 32'd0);
        check("rst_instr", 32'(instruction), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        // Fill and drain
        insReady = 1'b1;
        for (int i = 1; i <= 4; i++) write(mk(4'(i), 24'(16 * i)), 1'b1);
        check("fd_count", 32'(count), 32'd4);
        check("fd_full", 32'(full), 32'd1);
        check("fd_idle_hold", 32'(insValid), 32'd0);
        pulse_start();
        check("fd_running", 32'(running), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fd_consecutive", 32'(insValid), 32'd1);
        end
        tick();
        check("fd_end_valid", 32'(insValid), 32'd0);
        check("fd_end_count", 32'(count), 32'd0);

        // Backpressure
        insReady = 1'b0;
        w5 = mk(4'h5, 24'h000aa5);
        write(w5, 1'b1);
        write(mk(4'h6, 24'h000aa6), 1'b1);
        write(mk(4'h7, 24'h000aa7), 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(insValid), 32'd1);
            check("bp_stable", 32'(instruction), 32'(w5));
            check("bp_count", 32'(count), 32'd2);
            tick();
        end
        insReady = 1'b1;
        wait_drain("bp", 20);

        // NOP / HALT
        do_reset();
        insReady = 1'b1;
        write(mk(4'h1, 24'h000b01), 1'b1);
        write(mk(4'h0, 24'h000b0f), 1'b0);
        write(mk(4'h2, 24'h000b02), 1'b1);
        write(mk(4'hf, 24'h000bff), 1'b0);
        pulse_start();
        tick();
        tick();
        write(mk(4'h3, 24'h000b03), 1'b0);
        repeat (6) tick();
        check("nh_halted", 32'(halted), 32'd1);
        check("nh_running", 32'(running), 32'd0);
        check("nh_count", 32'(count), 32'd1);
        check("nh_valid", 32'(insValid), 32'd0);
        check("nh_sb_empty", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(mk(4'h3, 24'h000b03));
        pulse_start();
        check("nh_restart", 32'(running), 32'd1);
        wait_drain("nh", 20);

        // Full / overflow
        do_reset();
        insReady = 1'b1;
        for (int i = 1; i <= 4; i++) write(mk(4'(i), 24'(256 + i)), 1'b1);
        check("ov_full", 32'(full), 32'd1);
        check("ov_pre_overflow", 32'(overflow), 32'd0);
        write(mk(4'h9, 24'h000999), 1'b0);
        check("ov_overflow", 32'(overflow), 32'd1);
        check("ov_count", 32'(count), 32'd4);
        pulse_start();
        wait_drain("ov", 20);
        check("ov_sticky", 32'(overflow), 32'd1);
        check("ov_full_clear", 32'(full), 32'd0);

        // Wrap-around with interleaved writes and pops
        do_reset();
        pulse_start();
        sent = 0;
        max_cnt = 0;
        for (int cyc = 0; cyc < 200 && sent < 12; cyc++) begin
            insReady = (cyc % 3) != 2;
            if (!full && (cyc % 5) != 4) begin
                wrEn   = 1'b1;
                wrData = mk(4'(1 + sent % 13), 24'(24'hc00 + sent));
                exp_q.push_back(wrData);
                sent++;
            end else begin
                wrEn = 1'b0;
            end
            tick();
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        wrEn = 1'b0;
        insReady = 1'b1;
        check("wrap_sent", 32'(sent), 32'd12);
        wait_drain("wrap", 40);
        check("wrap_count_bound", 32'(max_cnt > 4), 32'd0);
        check("wrap_overflow", 32'(overflow), 32'd0);

        // Mid-run reset
        do_reset();
        insReady = 1'b0;
        pulse_start();
        write(mk(4'ha, 24'h000d01), 1'b0);
        write(mk(4'hb, 24'h000d02), 1'b0);
        write(mk(4'hc, 24'h000d03), 1'b0);
        write(mk(4'hd, 24'h000d04), 1'b0);
        check("mr_pre_valid", 32'(insValid), 32'd1);
        check("mr_pre_count", 32'(count), 32'd3);
        check("mr_pre_instr", 32'(instruction), 32'(mk(4'ha, 24'h000d01)));
        do_reset();
        check("mr_valid", 32'(insValid), 32'd0);
        check("mr_instr", 32'(instruction), 32'd0);
        check("mr_count", 32'(count), 32'd0);
        check("mr_running", 32'(running), 32'd0);
        insReady = 1'b1;
        pulse_start();
        write(mk(4'he, 24'h000e01), 1'b1);
        write(mk(4'h2, 24'h000e02), 1'b1);
        wait_drain("mr", 20);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
